// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//
// Receives the PS/2 keyboard serial stream, rebuilds scan-code set 2 bytes,
// resolves the E0 (extended) and F0 (break) prefixes, and keeps a 512-bit map
// of the keys that are currently held. The game core reads this map through
// key_down, last_change and key_valid.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   - a frame is rejected unless the data bits plus the parity bit
//               hold an odd number of ones
//   undefined - the parity bit is ignored and only the stop bit is checked
//
// Parameters
//   FILTER_LEN      consecutive identical samples needed to move the filtered clock
//   TIMEOUT_CYCLES  idle pclk cycles inside a frame before the frame is dropped
//
// Ports
//   pclk         system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   key_down     pressed-key map indexed by {ext, code}
//   last_change  index of the most recent make/break event
//   key_valid    one-cycle pulse per make/break event
//   frame_err    one-cycle pulse per discarded frame

module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid,
    output logic         frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frameState_e;

    logic [1:0]    clkSync_q;
    logic [1:0]    dataSync_q;
    logic          filtClk_q;
    logic          filtClk_d;
    logic [FW-1:0] filtCnt_q;
    logic [FW-1:0] filtCnt_d;
    logic          fallEdge;
    logic          dataBit;

    frameState_e   state_q;
    logic [2:0]    bitCnt_q;
    logic [7:0]    shift_q;
    logic [TW-1:0] toCnt_q;
    logic          byteValid_q;
    logic          frameErr_q;
    logic          parityOk;

    logic [511:0]  keyDown_q;
    logic [8:0]    lastChange_q;
    logic          keyValid_q;
    logic          ext_q;
    logic          brk_q;

    assign dataBit = dataSync_q[1];

`ifdef PS2_PARITY_CHECK_EN
    logic parityBit_q;
    assign parityOk = ^{shift_q, parityBit_q};
`else
    assign parityOk = 1'b1;
`endif

    // Glitch filter: the filtered clock only moves after FILTER_LEN samples in a
    // row disagree with it. The falling edge is flagged in the same cycle the
    // filtered level drops, so the FSM sees it without an extra register stage.
    always_comb begin
        filtClk_d = filtClk_q;
        filtCnt_d = '0;
        fallEdge  = 1'b0;
        if (clkSync_q[1] != filtClk_q) begin
            if (filtCnt_q == FW'(FILTER_LEN - 1)) begin
                filtClk_d = ~filtClk_q;
                fallEdge  = filtClk_q;
            end else begin
                filtCnt_d = filtCnt_q + 1'b1;
            end
        end
    end

    // Two-flop synchronizers for both pins plus the filter state. The
    // synchronizers reset to the idle-high bus level so that leaving reset
    // never looks like a clock edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            filtClk_q  <= 1'b1;
            filtCnt_q  <= '0;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk};
            dataSync_q <= {dataSync_q[0], ps2_data};
            filtClk_q  <= filtClk_d;
            filtCnt_q  <= filtCnt_d;
        end
    end

    // Frame receiver. Each filtered falling edge advances the frame by one bit.
    // While a frame is open, a silent bus for TIMEOUT_CYCLES abandons it so a
    // half-received frame cannot desynchronise every later byte.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            toCnt_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parityBit_q <= 1'b0;
`endif
        end else begin
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            if (fallEdge) begin
                toCnt_q <= '0;
                unique case (state_q)
                    IDLE: begin
                        if (!dataBit) begin
                            state_q  <= DATA;
                            bitCnt_q <= '0;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q  <= {dataBit, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 1'b1;
                        if (bitCnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parityBit_q <= dataBit;
`endif
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (dataBit && parityOk) begin
                            byteValid_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end else if (state_q != IDLE) begin
                if (toCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q    <= IDLE;
                    frameErr_q <= 1'b1;
                    toCnt_q    <= '0;
                end else begin
                    toCnt_q <= toCnt_q + 1'b1;
                end
            end else begin
                toCnt_q <= '0;
            end
        end
    end

    // Byte decoder. Prefix bytes only set flags; housekeeping bytes from the
    // keyboard (self-test, ack, resend, echo) are dropped without touching the
    // flags; anything else is a key event. Any discarded frame also drops the
    // pending prefixes so a lost byte cannot attach them to an unrelated key.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            keyDown_q    <= '0;
            lastChange_q <= '0;
            keyValid_q   <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            keyValid_q <= 1'b0;
            if (frameErr_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (byteValid_q) begin
                case (shift_q)
                    8'hE0: ext_q <= 1'b1;
                    8'hF0: brk_q <= 1'b1;
                    8'hAA, 8'hFA, 8'hFE, 8'hEE: begin
                    end
                    default: begin
                        keyDown_q[{ext_q, shift_q}] <= ~brk_q;
                        lastChange_q                <= {ext_q, shift_q};
                        keyValid_q                  <= 1'b1;
                        ext_q                       <= 1'b0;
                        brk_q                       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key_down    = keyDown_q;
    assign last_change = lastChange_q;
    assign key_valid   = keyValid_q;
    assign frame_err   = frameErr_q;

endmodule
